// File: rtl/data_mem_responder_pkg.sv
// Shared CPU definitions: memory opcodes, responder state encoding, default data width.
package data_mem_responder_pkg;
   localparam int DEF_DATA_WIDTH = 32;

   localparam logic [4:0] OPC_LOAD  = 5'b01001;
   localparam logic [4:0] OPC_STORE = 5'b01010;
   localparam logic [4:0] OPC_NONE  = 5'b00000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Both qualifiers set yields OPC_NONE, which the responder treats as illegal.
   function automatic logic [4:0] op_encode(input logic wr, input logic ld);
      logic [4:0] op;
      op = OPC_NONE;
      if (wr && !ld) begin
         op = OPC_STORE;
      end else if (ld && !wr) begin
         op = OPC_LOAD;
      end
      return op;
   endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// Control-unit to data-memory request/response bundle.
interface data_mem_responder_if
   import data_mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = 8
);
   logic                  mem_enable;
   logic                  mem_write;
   logic                  load;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  mem_ready;
   logic                  mem_busy;
   logic                  mem_error;

   modport master (
      output mem_enable, mem_write, load, addr, write_data,
      input  read_data, mem_ready, mem_busy, mem_error
   );

   modport slave (
      input  mem_enable, mem_write, load, addr, write_data,
      output read_data, mem_ready, mem_busy, mem_error
   );
endinterface

// File: rtl/data_mem_array.sv
// Word storage with synchronous write and a registered read port.
// Latency: write and read both take effect on the enabling edge.
// Backpressure: none; the responder issues at most one access per request.
module data_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_dat,
   input  logic                  rd_en,
   input  logic                  rd_clr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_dat
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;

   // Storage is deliberately left unreset; only the read register clears.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr[IW-1:0]] <= wr_dat;
      end
   end

   always_comb begin
      rd_dat_d = rd_dat_q;
      if (rd_clr) begin
         rd_dat_d = '0;
      end else if (rd_en) begin
         rd_dat_d = mem_q[rd_addr[IW-1:0]];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_dat_q <= '0;
      end else begin
         rd_dat_q <= rd_dat_d;
      end
   end

   assign rd_dat = rd_dat_q;
endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder for the CPU MEMORY state.
// Latency: commit WAIT_CYCLES edges after acceptance, mem_ready the following cycle.
// Backpressure: one request in flight; requests seen while busy are dropped, not queued.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   data_mem_responder_if.slave bus
);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
   logic [4:0]            op_q, op_d;
   logic                  err_q, err_d;

   logic                  req_hit;
   logic                  commit;
   logic [ADDR_WIDTH-1:0] c_addr;
   logic [DATA_WIDTH-1:0] c_wdat;
   logic [4:0]            c_op;
   logic                  c_illegal;
   logic [DATA_WIDTH-1:0] rd_dat;

   assign req_hit = bus.mem_enable && (bus.mem_write || bus.load);

   // With zero wait states the commit happens on the acceptance edge, so the
   // commit path must see the live bus rather than the capture registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      op_d    = op_q;
      err_d   = err_q;
      commit  = 1'b0;
      c_addr  = addr_q;
      c_wdat  = wdat_q;
      c_op    = op_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_hit) begin
               addr_d = bus.addr;
               wdat_d = bus.write_data;
               op_d   = op_encode(bus.mem_write, bus.load);
               cnt_d  = WAIT_INIT;
               c_addr = bus.addr;
               c_wdat = bus.write_data;
               c_op   = op_d;
               if (WAIT_CYCLES == 0) begin
                  commit  = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      c_illegal = (c_op == OPC_NONE) || (32'(c_addr) >= 32'(DEPTH));
      if (commit) begin
         err_d = c_illegal;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdat_q  <= '0;
         op_q    <= OPC_NONE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   data_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (commit && !c_illegal && (c_op == OPC_STORE)),
      .wr_addr (c_addr),
      .wr_dat  (c_wdat),
      .rd_en   (commit && !c_illegal && (c_op == OPC_LOAD)),
      .rd_clr  (commit && c_illegal),
      .rd_addr (c_addr),
      .rd_dat  (rd_dat)
   );

   assign bus.read_data = rd_dat;
   assign bus.mem_ready = (state_q == ST_RESP);
   assign bus.mem_busy  = (state_q != ST_IDLE);
   assign bus.mem_error = (state_q == ST_RESP) && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three configurations against a timestamp-based transaction model.
module tb_data_mem_responder;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NK = 3;

   function automatic int w_of(input int k);
      case (k)
         0:       return 2;
         1:       return 0;
         default: return 1;
      endcase
   endfunction

   function automatic int d_of(input int k);
      return (k == 2) ? 200 : 256;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_v [NK];
   logic          en_v  [NK];
   logic          wr_v  [NK];
   logic          ld_v  [NK];
   logic [AW-1:0] ad_v  [NK];
   logic [DW-1:0] wd_v  [NK];
   logic [DW-1:0] rd_v  [NK];
   logic          rdy_v [NK];
   logic          bsy_v [NK];
   logic          err_v [NK];

   int tests = 0;
   int fails = 0;

   for (genvar g = 0; g < NK; g++) begin : g_dut
      data_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
      assign bus.mem_enable = en_v[g];
      assign bus.mem_write  = wr_v[g];
      assign bus.load       = ld_v[g];
      assign bus.addr       = ad_v[g];
      assign bus.write_data = wd_v[g];
      assign rd_v[g]        = bus.read_data;
      assign rdy_v[g]       = bus.mem_ready;
      assign bsy_v[g]       = bus.mem_busy;
      assign err_v[g]       = bus.mem_error;

      data_mem_responder #(
         .DATA_WIDTH  (DW),
         .ADDR_WIDTH  (AW),
         .DEPTH       (d_of(g)),
         .WAIT_CYCLES (w_of(g))
      ) u_dut (
         .clk   (clk),
         .reset (rst_v[g]),
         .bus   (bus)
      );
   end

   // Model: a request accepted at edge c commits at edge c+W, is reported
   // after that edge, and the edge after the report is dead for acceptance.
   int            cyc = 0;
   bit            inflight [NK];
   int            t_commit [NK];
   bit            m_ill    [NK];
   bit            m_wr     [NK];
   logic [AW-1:0] m_ad     [NK];
   logic [DW-1:0] m_wd     [NK];
   logic [DW-1:0] mmem     [NK][256];
   bit            mknown   [NK][256];
   logic [DW-1:0] exp_rd   [NK];
   bit            rd_known [NK];

   task automatic model_clear(input int k);
      inflight[k] = 1'b0;
      t_commit[k] = 0;
      exp_rd[k]   = '0;
      rd_known[k] = 1'b1;
   endtask

   task automatic model_step(input int k);
      if (inflight[k]) begin
         if (cyc == t_commit[k] + 1) inflight[k] = 1'b0;
      end else if (en_v[k] && (wr_v[k] || ld_v[k])) begin
         inflight[k] = 1'b1;
         t_commit[k] = cyc + w_of(k);
         m_ill[k]    = (wr_v[k] && ld_v[k]) || (int'(ad_v[k]) >= d_of(k));
         m_wr[k]     = wr_v[k];
         m_ad[k]     = ad_v[k];
         m_wd[k]     = wd_v[k];
      end
      if (inflight[k] && cyc == t_commit[k]) begin
         if (m_ill[k]) begin
            exp_rd[k]   = '0;
            rd_known[k] = 1'b1;
         end else if (m_wr[k]) begin
            mmem[k][m_ad[k]]   = m_wd[k];
            mknown[k][m_ad[k]] = 1'b1;
         end else begin
            exp_rd[k]   = mmem[k][m_ad[k]];
            rd_known[k] = mknown[k][m_ad[k]];
         end
      end
   endtask

   // Resets are only raised while clk is low, so clk==1 identifies a clock edge.
   always @(posedge clk or posedge rst_v[0] or posedge rst_v[1] or posedge rst_v[2]) begin
      if (clk) cyc++;
      for (int k = 0; k < NK; k++) begin
         if (rst_v[k]) model_clear(k);
         else if (clk) model_step(k);
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : cmp
      bit eb;
      bit er;
      for (int k = 0; k < NK; k++) begin
         eb = inflight[k] && (cyc <= t_commit[k]);
         er = inflight[k] && (cyc == t_commit[k]);
         chk($sformatf("dut%0d mem_busy @%0d", k, cyc), 32'(bsy_v[k]), 32'(eb));
         chk($sformatf("dut%0d mem_ready @%0d", k, cyc), 32'(rdy_v[k]), 32'(er));
         chk($sformatf("dut%0d mem_error @%0d", k, cyc), 32'(err_v[k]), 32'(er && m_ill[k]));
         if (rd_known[k]) chk($sformatf("dut%0d read_data @%0d", k, cyc), rd_v[k], exp_rd[k]);
      end
   end

   task automatic drive(input int k, input bit en, input bit wr, input bit ld,
                        input logic [AW-1:0] ad, input logic [DW-1:0] wd);
      en_v[k] = en;
      wr_v[k] = wr;
      ld_v[k] = ld;
      ad_v[k] = ad;
      wd_v[k] = wd;
   endtask

   task automatic wait_ready(input int k, input bit drop, output int lat, output int nbusy, output logic err);
      bit seen;
      seen  = 1'b0;
      lat   = 0;
      nbusy = 0;
      err   = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (bsy_v[k]) nbusy++;
         if (rdy_v[k]) begin
            seen = 1'b1;
            err  = err_v[k];
         end
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL dut%0d ready timeout: no mem_ready within 40 cycles", k);
      end
      if (drop) drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic op(input int k, input bit wr, input bit ld, input logic [AW-1:0] ad,
                     input logic [DW-1:0] wd, output int lat, output int nbusy, output logic err);
      @(negedge clk);
      drive(k, 1'b1, wr, ld, ad, wd);
      wait_ready(k, 1'b1, lat, nbusy, err);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : main
      int   lat;
      int   nb;
      logic err;
      for (int k = 0; k < NK; k++) begin
         rst_v[k] = 1'b1;
         drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
         model_clear(k);
         for (int a = 0; a < 256; a++) mknown[k][a] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         chk($sformatf("reset dut%0d read_data", k), rd_v[k], 32'h0);
         chk($sformatf("reset dut%0d busy", k), 32'(bsy_v[k]), 32'd0);
         rst_v[k] = 1'b0;
      end

      // WAIT_CYCLES=2 store then load
      op(0, 1'b1, 1'b0, 8'd5, 32'hDEADBEEF, lat, nb, err);
      chk("store latency", 32'(lat), 32'd3);
      chk("store busy cycles", 32'(nb), 32'd3);
      chk("store error", 32'(err), 32'd0);
      @(negedge clk);
      chk("store busy after resp", 32'(bsy_v[0]), 32'd0);
      op(0, 1'b0, 1'b1, 8'd5, 32'h0, lat, nb, err);
      chk("load latency", 32'(lat), 32'd3);
      chk("load data", rd_v[0], 32'hDEADBEEF);
      op(0, 1'b1, 1'b0, 8'd6, 32'h11, lat, nb, err);
      chk("read_data held over store", rd_v[0], 32'hDEADBEEF);

      // WAIT_CYCLES=0 alternating store/load
      op(1, 1'b1, 1'b0, 8'd0, 32'h1, lat, nb, err);
      chk("w0 store latency", 32'(lat), 32'd1);
      op(1, 1'b0, 1'b1, 8'd0, 32'h0, lat, nb, err);
      chk("w0 load 1", rd_v[1], 32'h1);
      op(1, 1'b1, 1'b0, 8'd0, 32'h2, lat, nb, err);
      op(1, 1'b0, 1'b1, 8'd0, 32'h0, lat, nb, err);
      chk("w0 load 2", rd_v[1], 32'h2);

      // DEPTH=200 range and qualifier errors
      op(2, 1'b1, 1'b0, 8'd10, 32'h77, lat, nb, err);
      op(2, 1'b0, 1'b1, 8'd210, 32'h0, lat, nb, err);
      chk("oob load error", 32'(err), 32'd1);
      chk("oob load data", rd_v[2], 32'h0);
      chk("w1 latency", 32'(lat), 32'd2);
      op(2, 1'b1, 1'b0, 8'd210, 32'h55, lat, nb, err);
      chk("oob store error", 32'(err), 32'd1);
      op(2, 1'b0, 1'b1, 8'd10, 32'h0, lat, nb, err);
      chk("no alias data", rd_v[2], 32'h77);
      chk("no alias error", 32'(err), 32'd0);
      op(2, 1'b1, 1'b1, 8'd10, 32'h99, lat, nb, err);
      chk("both qualifiers error", 32'(err), 32'd1);
      chk("both qualifiers data", rd_v[2], 32'h0);
      op(2, 1'b0, 1'b1, 8'd10, 32'h0, lat, nb, err);
      chk("both qualifiers no write", rd_v[2], 32'h77);

      // reset one cycle before the commit edge, released just before it
      op(0, 1'b1, 1'b0, 8'd3, 32'h1234, lat, nb, err);
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 1'b0, 8'd3, 32'hAAAA);
      @(negedge clk);
      #1;
      rst_v[0] = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      chk("mid reset busy", 32'(bsy_v[0]), 32'd0);
      chk("mid reset ready", 32'(rdy_v[0]), 32'd0);
      chk("mid reset error", 32'(err_v[0]), 32'd0);
      chk("mid reset data", rd_v[0], 32'h0);
      #12;
      rst_v[0] = 1'b0;
      op(0, 1'b0, 1'b1, 8'd3, 32'h0, lat, nb, err);
      chk("reset discarded store", rd_v[0], 32'h1234);

      // request changed during WAIT and held through RESP is ignored
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b1, 8'd5, 32'h0);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b1, 8'd6, 32'h0);
      wait_ready(0, 1'b0, lat, nb, err);
      chk("captured addr data", rd_v[0], 32'hDEADBEEF);
      @(negedge clk);
      chk("resp ignores request", 32'(bsy_v[0]), 32'd0);
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk("idle after ignored request", 32'(bsy_v[0]), 32'd0);

      // request held past RESP is re-accepted: throughput W+2
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b1, 8'd6, 32'h0);
      wait_ready(0, 1'b0, lat, nb, err);
      wait_ready(0, 1'b1, lat, nb, err);
      chk("back-to-back spacing", 32'(lat), 32'd4);
      chk("re-accepted load data", rd_v[0], 32'h11);

      // enable without qualifier is not a request
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 1'b0, 8'd7, 32'h0);
      repeat (4) begin
         @(negedge clk);
         chk("no qualifier busy", 32'(bsy_v[0]), 32'd0);
      end
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
